// File: rtl/corner_tracker.sv
// rtl/corner_tracker.sv - tracks four marker corners per frame and their top-edge squared length
//
// Purpose: in SCAN, every in-range marker pixel refines four extreme-point
// candidates (min x+y, max x-y, max y-x, max x+y). A pulse on frame_end
// moves through COMMIT -> SQUARE -> SUM. The candidates are published only
// if the frame had at least p_min_hits hits. SUM then writes scale_dist and
// pulses corners_valid.
//
// Ports:
//   clk, reset (sync, active-low)
//   VGA_X, VGA_Y [10:0]        raster position of current pixel
//   marker_hit, frame_end      pixel classification / end-of-frame pulse
//   top_left_x/y, top_right_x/y, bot_left_x/y, bot_right_x/y [10:0]  committed corners
//   scale_dist [22:0]          |top_right - top_left|^2
//   corners_valid              one-cycle pulse when corners and scale_dist are fresh
//   hit_count [15:0]           saturating hit total of last completed frame
//
// Build option: define CORNER_SMOOTH_EN to average each new corner with the
// previous one, (old+new+1)>>1. The first commit after reset is not averaged.
module corner_tracker #(
    parameter int p_image_width  = 640,
    parameter int p_image_height = 480,
    parameter int p_min_hits     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] VGA_X,
    input  logic [10:0] VGA_Y,
    input  logic        marker_hit,
    input  logic        frame_end,
    output logic [10:0] top_left_x,
    output logic [10:0] top_left_y,
    output logic [10:0] top_right_x,
    output logic [10:0] top_right_y,
    output logic [10:0] bot_left_x,
    output logic [10:0] bot_left_y,
    output logic [10:0] bot_right_x,
    output logic [10:0] bot_right_y,
    output logic [22:0] scale_dist,
    output logic        corners_valid,
    output logic [15:0] hit_count
);

    typedef enum logic [1:0] {S_SCAN, S_COMMIT, S_SQUARE, S_SUM} state_t;

    state_t r_state;
    state_t w_next_state;

    // Corner arrays are indexed as: 0/1 TL x/y, 2/3 TR x/y, 4/5 BL x/y, 6/7 BR x/y.
    logic [10:0] r_cand   [8];
    logic [10:0] r_corner [8];
    logic [10:0] w_new    [8];

    logic        r_any;
    logic        r_commit_ok;
    logic [15:0] r_hits;
    logic [19:0] r_dx2;
    logic [19:0] r_dy2;
`ifdef CORNER_SMOOTH_EN
    logic        r_seeded;
`endif

    logic w_is_commit;
    logic w_is_square;
    logic w_is_sum;
    logic w_hit;
    logic w_fresh;
    logic w_enough;

    logic signed [12:0] w_px, w_py;
    logic signed [12:0] w_p_sum, w_p_dxy, w_p_dyx;
    logic signed [12:0] w_tl_sc, w_tr_sc, w_bl_sc, w_br_sc;
    logic signed [11:0] w_dx, w_dy;
    logic [19:0] w_dx_ext, w_dy_ext;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_SCAN;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_SCAN:   if (frame_end) w_next_state = S_COMMIT;
            S_COMMIT: w_next_state = S_SQUARE;
            S_SQUARE: w_next_state = S_SUM;
            default:  w_next_state = S_SCAN;
        endcase
    end

    always_comb begin
        w_is_commit = 1'b0;
        w_is_square = 1'b0;
        w_is_sum    = 1'b0;
        case (r_state)
            S_COMMIT: w_is_commit = 1'b1;
            S_SQUARE: w_is_square = 1'b1;
            S_SUM:    w_is_sum    = 1'b1;
            default:  ;
        endcase
    end

    assign w_hit = marker_hit && (32'(VGA_X) < p_image_width) && (32'(VGA_Y) < p_image_height);
    // The candidates are cleared during COMMIT, so a hit in that cycle restarts the frame.
    assign w_fresh  = w_is_commit || !r_any;
    assign w_enough = 32'(r_hits) >= p_min_hits;

    assign w_px    = {2'b00, VGA_X};
    assign w_py    = {2'b00, VGA_Y};
    assign w_p_sum = w_px + w_py;
    assign w_p_dxy = w_px - w_py;
    assign w_p_dyx = w_py - w_px;

    assign w_tl_sc = {2'b00, r_cand[0]} + {2'b00, r_cand[1]};
    assign w_tr_sc = {2'b00, r_cand[2]} - {2'b00, r_cand[3]};
    assign w_bl_sc = {2'b00, r_cand[5]} - {2'b00, r_cand[4]};
    assign w_br_sc = {2'b00, r_cand[6]} + {2'b00, r_cand[7]};

    // Sign-extend to the 20-bit product width; the low 20 bits of the square are exact.
    assign w_dx     = {1'b0, r_corner[2]} - {1'b0, r_corner[0]};
    assign w_dy     = {1'b0, r_corner[3]} - {1'b0, r_corner[1]};
    assign w_dx_ext = {{8{w_dx[11]}}, w_dx};
    assign w_dy_ext = {{8{w_dy[11]}}, w_dy};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef CORNER_SMOOTH_EN
            w_new[i] = r_seeded ? 11'(({1'b0, r_corner[i]} + {1'b0, r_cand[i]} + 12'd1) >> 1)
                                : r_cand[i];
`else
            w_new[i] = r_cand[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_cand[i]   <= '0;
                r_corner[i] <= '0;
            end
            r_any         <= 1'b0;
            r_commit_ok   <= 1'b0;
            r_hits        <= '0;
            r_dx2         <= '0;
            r_dy2         <= '0;
            hit_count     <= '0;
            scale_dist    <= '0;
            corners_valid <= 1'b0;
`ifdef CORNER_SMOOTH_EN
            r_seeded      <= 1'b0;
`endif
        end else begin
            // Candidate tracking runs in every state; strict compares keep the earliest tie.
            if (w_hit) begin
                if (w_fresh || w_p_sum < w_tl_sc) begin
                    r_cand[0] <= VGA_X; r_cand[1] <= VGA_Y;
                end
                if (w_fresh || w_p_dxy > w_tr_sc) begin
                    r_cand[2] <= VGA_X; r_cand[3] <= VGA_Y;
                end
                if (w_fresh || w_p_dyx > w_bl_sc) begin
                    r_cand[4] <= VGA_X; r_cand[5] <= VGA_Y;
                end
                if (w_fresh || w_p_sum > w_br_sc) begin
                    r_cand[6] <= VGA_X; r_cand[7] <= VGA_Y;
                end
                r_any <= 1'b1;
            end else if (w_is_commit) begin
                for (int i = 0; i < 8; i++) r_cand[i] <= '0;
                r_any <= 1'b0;
            end

            if (w_is_commit)
                r_hits <= w_hit ? 16'd1 : 16'd0;
            else if (w_hit && r_hits != 16'hFFFF)
                r_hits <= r_hits + 16'd1;

            if (w_is_commit) begin
                hit_count   <= r_hits;
                r_commit_ok <= w_enough;
                if (w_enough) begin
                    for (int i = 0; i < 8; i++) r_corner[i] <= w_new[i];
`ifdef CORNER_SMOOTH_EN
                    r_seeded <= 1'b1;
`endif
                end
            end

            if (w_is_square) begin
                r_dx2 <= w_dx_ext * w_dx_ext;
                r_dy2 <= w_dy_ext * w_dy_ext;
            end

            corners_valid <= 1'b0;
            if (w_is_sum && r_commit_ok) begin
                scale_dist    <= {3'b000, r_dx2} + {3'b000, r_dy2};
                corners_valid <= 1'b1;
            end
        end
    end

    assign top_left_x  = r_corner[0];
    assign top_left_y  = r_corner[1];
    assign top_right_x = r_corner[2];
    assign top_right_y = r_corner[3];
    assign bot_left_x  = r_corner[4];
    assign bot_left_y  = r_corner[5];
    assign bot_right_x = r_corner[6];
    assign bot_right_y = r_corner[7];

endmodule

// File: tb/tb_corner_tracker.sv
// tb/tb_corner_tracker.sv - self-checking bench for corner_tracker
module tb_corner_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] VGA_X, VGA_Y;
    logic        marker_hit, frame_end;
    logic [10:0] top_left_x, top_left_y, top_right_x, top_right_y;
    logic [10:0] bot_left_x, bot_left_y, bot_right_x, bot_right_y;
    logic [22:0] scale_dist;
    logic        corners_valid;
    logic [15:0] hit_count;

    always #5 clk = ~clk;

    corner_tracker dut (
        .clk(clk), .reset(reset), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
        .marker_hit(marker_hit), .frame_end(frame_end),
        .top_left_x(top_left_x), .top_left_y(top_left_y),
        .top_right_x(top_right_x), .top_right_y(top_right_y),
        .bot_left_x(bot_left_x), .bot_left_y(bot_left_y),
        .bot_right_x(bot_right_x), .bot_right_y(bot_right_y),
        .scale_dist(scale_dist), .corners_valid(corners_valid), .hit_count(hit_count)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_pulse = 0;
    bit mon_en  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the frame's hits are kept as a list; the corners are
    // found by searching that list when the frame ends. Results appear on the
    // outputs with the documented delays: corners and hit_count 1 cycle
    // after frame_end, scale_dist and corners_valid 3 cycles after it.
    int q_x[$];
    int q_y[$];
    int e_c[8];
    int e_scale, e_valid, e_hc;
    int p_c[8];
    int p_n;
    int m_after;   // cycles elapsed since the frame_end sample, 0 when idle
    bit m_ok, m_seeded;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) e_c[i] = 0;
        e_scale = 0; e_valid = 0; e_hc = 0;
        q_x.delete(); q_y.delete();
        m_after = 0; m_ok = 0; m_seeded = 0;
    endtask

    task automatic model_frame();
        int btl, btr, bbl, bbr;
        p_n = q_x.size();
        for (int k = 0; k < p_n; k++) begin
            int x, y;
            x = q_x[k]; y = q_y[k];
            if (k == 0 || x + y < btl) begin btl = x + y; p_c[0] = x; p_c[1] = y; end
            if (k == 0 || x - y > btr) begin btr = x - y; p_c[2] = x; p_c[3] = y; end
            if (k == 0 || y - x > bbl) begin bbl = y - x; p_c[4] = x; p_c[5] = y; end
            if (k == 0 || x + y > bbr) begin bbr = x + y; p_c[6] = x; p_c[7] = y; end
        end
        q_x.delete(); q_y.delete();
    endtask

    task automatic model_step(input bit rst_n, input int x, input int y, input bit hit, input bit fe);
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_valid = 0;
        if (m_after == 1) begin
            e_hc = (p_n > 65535) ? 65535 : p_n;
            m_ok = (p_n >= 16);
            if (m_ok) begin
                for (int i = 0; i < 8; i++)
                    e_c[i] = m_seeded ? (e_c[i] + p_c[i] + 1) / 2 : p_c[i];
`ifdef CORNER_SMOOTH_EN
                m_seeded = 1;
`endif
            end
        end else if (m_after == 3 && m_ok) begin
            e_scale = (e_c[2] - e_c[0]) * (e_c[2] - e_c[0]) + (e_c[3] - e_c[1]) * (e_c[3] - e_c[1]);
            e_valid = 1;
        end
        if (hit && x < 640 && y < 480) begin
            q_x.push_back(x);
            q_y.push_back(y);
        end
        if (m_after == 0) begin
            if (fe) begin
                model_frame();
                m_after = 1;
            end
        end else begin
            m_after = (m_after == 3) ? 0 : m_after + 1;
            if (m_after == 0) m_after = 0;
            else if (m_after == 2 || m_after == 3) ;
        end
    endtask

    // m_after counts 1 (COMMIT edge), 2, 3 and wraps to 0 after the SUM edge.
    task automatic cyc(input int x, input int y, input bit hit, input bit fe);
        VGA_X = 11'(x); VGA_Y = 11'(y); marker_hit = hit; frame_end = fe;
        @(posedge clk);
        model_step(reset, x, y, hit, fe);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("tl_x", top_left_x, e_c[0]);
            chk("tl_y", top_left_y, e_c[1]);
            chk("tr_x", top_right_x, e_c[2]);
            chk("tr_y", top_right_y, e_c[3]);
            chk("bl_x", bot_left_x, e_c[4]);
            chk("bl_y", bot_left_y, e_c[5]);
            chk("br_x", bot_right_x, e_c[6]);
            chk("br_y", bot_right_y, e_c[7]);
            chk("scale_dist", scale_dist, e_scale);
            chk("corners_valid", corners_valid, e_valid);
            chk("hit_count", hit_count, e_hc);
            if (corners_valid) n_pulse++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        int pulses;
        reset = 1'b0;
        VGA_X = '0; VGA_Y = '0; marker_hit = 1'b0; frame_end = 1'b0;
        #1;
        cyc(0, 0, 0, 0);
        mon_en = 1;
        cyc(0, 0, 0, 0);
        chk("reset_tl_x", top_left_x, 0);
        chk("reset_scale", scale_dist, 0);
        chk("reset_hit_count", hit_count, 0);
        chk("reset_valid", corners_valid, 0);
        reset = 1'b1;
        idle(2);

        // 81x41 filled rectangle
        for (int y = 200; y <= 240; y++)
            for (int x = 100; x <= 180; x++)
                cyc(x, y, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("rect_tl_x", top_left_x, 100);
        chk("rect_tl_y", top_left_y, 200);
        chk("rect_tr_x", top_right_x, 180);
        chk("rect_bl_y", bot_left_y, 240);
        chk("rect_br_x", bot_right_x, 180);
        chk("rect_br_y", bot_right_y, 240);
        chk("rect_hit_count", hit_count, 3321);
        chk("rect_valid_lat1", corners_valid, 0);
        cyc(0, 0, 0, 0);
        chk("rect_valid_lat2", corners_valid, 0);
        cyc(0, 0, 0, 0);
        chk("rect_valid_lat3", corners_valid, 1);
        chk("rect_scale", scale_dist, 6400);
        idle(2);

        // Too few hits; the next frame's hits arrive during COMMIT/SQUARE
        pulses = n_pulse;
        for (int x = 300; x < 310; x++) cyc(x, 300, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(639, 479, 1, 0);
        cyc(640, 10, 1, 0);
        idle(2);
        chk("few_hit_count", hit_count, 10);
        chk("few_tl_x", top_left_x, 100);
        chk("few_scale", scale_dist, 6400);
        chk("few_no_pulse", n_pulse, pulses);

        // Frame holding only the edge-of-image hit
        cyc(0, 0, 0, 1);
        idle(4);
        chk("edge_hit_count", hit_count, 1);

        // Hit on the frame_end cycle wins top-left
        for (int x = 60; x < 80; x++) cyc(x, 60, 1, 0);
        cyc(50, 50, 1, 1);
        idle(3);
        chk("fe_hit_valid", corners_valid, 1);
`ifdef CORNER_SMOOTH_EN
        chk("fe_hit_tl_x", top_left_x, 75);
        chk("fe_hit_tl_y", top_left_y, 125);
`else
        chk("fe_hit_tl_x", top_left_x, 50);
        chk("fe_hit_tl_y", top_left_y, 50);
`endif
        chk("fe_hit_count", hit_count, 21);
        idle(2);

        // Reset while in SQUARE
        pulses = n_pulse;
        for (int x = 200; x < 220; x++) cyc(x, 100, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        reset = 1'b1;
        idle(4);
        chk("rst_sq_no_pulse", n_pulse, pulses);
        chk("rst_sq_tl_x", top_left_x, 0);
        chk("rst_sq_scale", scale_dist, 0);
        chk("rst_sq_hit_count", hit_count, 0);
        for (int x = 10; x < 40; x++) cyc(x, 20, 1, 0);
        cyc(0, 0, 0, 1);
        idle(3);
        chk("post_rst_valid", corners_valid, 1);
        chk("post_rst_tl_x", top_left_x, 10);
        chk("post_rst_tr_x", top_right_x, 39);
        chk("post_rst_bl_x", bot_left_x, 10);
        chk("post_rst_scale", scale_dist, 841);
        idle(2);

`ifdef CORNER_SMOOTH_EN
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        reset = 1'b1;
        for (int x = 100; x < 120; x++) cyc(x, 200, 1, 0);
        cyc(0, 0, 0, 1);
        idle(4);
        chk("smooth_first_tl_x", top_left_x, 100);
        for (int x = 110; x < 130; x++) cyc(x, 210, 1, 0);
        cyc(0, 0, 0, 1);
        idle(4);
        chk("smooth_tl_x", top_left_x, 105);
        chk("smooth_tl_y", top_left_y, 205);
`endif

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/corner_tracker.md
CORNER_TRACKER -- requirements
Module: corner_tracker

Interface
REQ-001 SHALL have parameter p_image_width, default 640, meaning active pixels per line; hits with VGA_X >= p_image_width are ignored.
REQ-002 SHALL have parameter p_image_height, default 480, meaning active lines; hits with VGA_Y >= p_image_height are ignored.
REQ-003 SHALL have parameter p_min_hits, default 16, meaning the minimum marker hits per frame needed to commit new corners.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port VGA_X, input, 11 bits, unsigned: raster x of the current pixel.
REQ-007 SHALL have port VGA_Y, input, 11 bits, unsigned: raster y of the current pixel.
REQ-008 SHALL have port marker_hit, input, 1 bit: the current pixel is classified as marker colour.
REQ-009 SHALL have port frame_end, input, 1 bit: single-cycle pulse after the last active pixel of a frame.
REQ-010 SHALL have ports top_left_x/y, top_right_x/y, bot_left_x/y, bot_right_x/y, outputs, 11 bits each, unsigned: the committed corners.
REQ-011 SHALL have port scale_dist, output, 23 bits, unsigned: squared distance from top_left to top_right.
REQ-012 SHALL have port corners_valid, output, 1 bit: one-cycle pulse when new corners and scale_dist are both updated.
REQ-013 SHALL have port hit_count, output, 16 bits: hit total of the last completed frame, saturating.

Function
REQ-014 SHALL run the FSM states SCAN -> COMMIT -> SQUARE -> SUM -> SCAN, with one cycle in each state other than SCAN.
REQ-015 SHALL, in SCAN, for each in-range pixel with marker_hit=1, apply these updates:
- top_left = argmin(x+y).
- bot_right = argmax(x+y).
- top_right = argmax(x-y).
- bot_left = argmax(y-x).
- Arithmetic is 13-bit signed.
REQ-016 SHALL update a candidate only on strict improvement, so the first hit in raster order wins ties.
REQ-017 SHALL increment the hit counter on each counted hit, saturating at 16'hFFFF.
REQ-018 SHALL, when frame_end=1 in SCAN, include any hit in that same cycle, then enter COMMIT.
REQ-019 SHALL, in COMMIT with hits >= p_min_hits, latch the four candidates onto the corner outputs.
REQ-020 SHALL, in COMMIT with hits < p_min_hits, hold the previous corners and scale_dist, and suppress corners_valid.
REQ-021 SHALL, in COMMIT, always load hit_count, then clear the candidates and the counter.
REQ-022 SHALL, in SQUARE, register dx^2 and dy^2 into 20-bit registers, where dx = top_right_x - top_left_x and dy = top_right_y - top_left_y, both 12-bit signed.
REQ-023 SHALL, in SUM, write scale_dist = dx^2 + dy^2, zero-extended to 23 bits, and pulse corners_valid in the same cycle if the commit succeeded.
REQ-024 SHALL give a latency of 3 cycles from the frame_end sample to the corners_valid pulse; corners change 1 cycle after frame_end.
REQ-025 SHALL accumulate hits into the next frame during COMMIT/SQUARE/SUM; frame_end outside SCAN is ignored.

Reset
REQ-026 SHALL, with reset=0 at a clock edge, zero all outputs, candidates and counter, and enter SCAN.
REQ-027 SHALL, on reset mid-frame or mid-calculation, discard partial results; no corners_valid follows.

Configuration
REQ-028 SHALL, when macro CORNER_SMOOTH_EN is defined, make COMMIT write each corner coordinate as (old+new+1)>>1.
REQ-029 SHALL, when CORNER_SMOOTH_EN is defined, write the raw candidates on the first successful commit after reset.
REQ-030 SHALL, when CORNER_SMOOTH_EN is undefined, write the candidates directly.

Verification
REQ-031 SHALL cover: an 81x41 filled rectangle at x 100..180, y 200..240, with 3321 hits, then frame_end -> TL=(100,200), TR=(180,200), BL=(100,240), BR=(180,240), scale_dist=6400, corners_valid exactly 3 cycles later.
REQ-032 SHALL cover: 10 hits then frame_end (p_min_hits=16) -> corners and scale_dist unchanged, no corners_valid, hit_count=10.
REQ-033 SHALL cover: one hit at (639,479) and one at (640,10), then frame_end -> only the first is counted, hit_count=1.
REQ-034 SHALL cover: a hit in the same cycle as frame_end at (50,50), plus 20 earlier hits at (60..79,60) -> TL=(50,50) is committed.
REQ-035 SHALL cover: reset=0 during SQUARE -> outputs 0, no pulse, and the next full frame commits normally.
REQ-036 SHALL cover, with CORNER_SMOOTH_EN defined: commit TL=(100,200), then TL=(110,210) -> TL=(105,205).
